// File: rtl/imem_dmem_arbiter.sv
// Shares one fixed-latency single-port SRAM between instruction fetch (IF) and data access (MEM).
// MEM wins ties until STARVE_LIMIT grants; a branch squashes the in-flight fetch result.
module imem_dmem_arbiter #(
  parameter int LATENCY      = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        branch_taken_i,
  output logic        if_rdy_o,
  output logic [31:0] if_rdata_o,
  output logic        freeze_o,
  input  logic        mem_rd_en_i,
  input  logic        mem_wr_en_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic        mem_rdy_o,
  output logic [31:0] mem_rdata_o,
  output logic        mem_stall_o,
  output logic        sram_en_o,
  output logic        sram_we_o,
  output logic [31:0] sram_addr_o,
  output logic [31:0] sram_wdata_o,
  input  logic [31:0] sram_rdata_i
);

  localparam int CW = $clog2(LATENCY) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(LATENCY - 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q;
  logic          squash_q;
  logic          if_rdy_q, mem_rdy_q;
  logic [31:0]   if_rdata_q, mem_rdata_q;
  logic          sram_en_q, sram_we_q;
  logic [31:0]   sram_addr_q, sram_wdata_q;

  logic mem_req, mem_v, if_v, done, done_if, done_mem, if_hit;
  logic grant_if, grant_mem;

  // A requester whose rdy pulse is showing still holds its old request; mask it.
  assign mem_req  = mem_rd_en_i | mem_wr_en_i;
  assign mem_v    = mem_req & ~mem_rdy_q;
  assign if_v     = if_req_i & ~branch_taken_i & ~if_rdy_q;
  assign done     = (state_q != IDLE) && (cnt_q == '0);
  assign done_if  = done && (state_q == BUSY_IF);
  assign done_mem = done && (state_q == BUSY_MEM);
  assign if_hit   = done_if & ~squash_q & ~branch_taken_i;

  always_comb begin
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_v && ((streak_q < STREAK_MAX) || !if_req_i)) grant_mem = 1'b1;
        else if (if_v)                                        grant_if  = 1'b1;
      end
      BUSY_IF:  grant_mem = done & mem_v;
      BUSY_MEM: grant_if  = done & if_v;
      default: ;
    endcase
    if (grant_mem) begin
      state_d = BUSY_MEM;
      cnt_d   = CNT_LOAD;
    end else if (grant_if) begin
      state_d = BUSY_IF;
      cnt_d   = CNT_LOAD;
    end else if (done) begin
      state_d = IDLE;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak_q     <= '0;
      squash_q     <= 1'b0;
      if_rdy_q     <= 1'b0;
      mem_rdy_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      if_rdy_q  <= if_hit;
      mem_rdy_q <= done_mem;
      if (if_hit)                 if_rdata_q  <= sram_rdata_i;
      if (done_mem && !sram_we_q) mem_rdata_q <= sram_rdata_i;

      if (done_if)                                         squash_q <= 1'b0;
      else if ((state_q == BUSY_IF) && branch_taken_i)     squash_q <= 1'b1;

      if (!if_req_i || grant_if)                           streak_q <= '0;
      else if (grant_mem && (streak_q < STREAK_MAX))       streak_q <= streak_q + 1'b1;

      sram_en_q <= (state_d != IDLE);
      if (grant_mem) begin
        sram_addr_q  <= mem_addr_i;
        sram_we_q    <= mem_wr_en_i;
        sram_wdata_q <= mem_wdata_i;
      end else if (grant_if) begin
        sram_addr_q <= if_addr_i;
        sram_we_q   <= 1'b0;
      end else if (state_d == IDLE) begin
        sram_we_q <= 1'b0;
      end
    end
  end

  assign if_rdy_o     = if_rdy_q;
  assign if_rdata_o   = if_rdata_q;
  assign mem_rdy_o    = mem_rdy_q;
  assign mem_rdata_o  = mem_rdata_q;
  assign sram_en_o    = sram_en_q;
  assign sram_we_o    = sram_we_q;
  assign sram_addr_o  = sram_addr_q;
  assign sram_wdata_o = sram_wdata_q;
  assign freeze_o     = if_req_i & ~if_rdy_q;
  assign mem_stall_o  = mem_req & ~mem_rdy_q;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Bench for imem_dmem_arbiter: directed scenarios plus a randomized run against a memory scoreboard.
module tb_imem_dmem_arbiter;
  localparam int LAT = 2;
  localparam int SL  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, branch_taken, mem_rd_en, mem_wr_en;
  logic [31:0] if_addr, mem_addr, mem_wdata, sram_rdata;
  logic        if_rdy, freeze, mem_rdy, mem_stall, sram_en, sram_we;
  logic [31:0] if_rdata, mem_rdata, sram_addr, sram_wdata;
  logic [31:0] smem [1024];
  logic [31:0] rmem [1024];
  int          ph;
  logic        was_en;
  int          total = 0;
  int          bad   = 0;

  imem_dmem_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .branch_taken_i(branch_taken),
    .if_rdy_o(if_rdy), .if_rdata_o(if_rdata), .freeze_o(freeze),
    .mem_rd_en_i(mem_rd_en), .mem_wr_en_i(mem_wr_en), .mem_addr_i(mem_addr),
    .mem_wdata_i(mem_wdata), .mem_rdy_o(mem_rdy), .mem_rdata_o(mem_rdata),
    .mem_stall_o(mem_stall), .sram_en_o(sram_en), .sram_we_o(sram_we),
    .sram_addr_o(sram_addr), .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'hE3A00001;
    return 32'hC0DE0000 + 32'(i) * 32'd13;
  endfunction

  task automatic init_mems();
    for (int i = 0; i < 1024; i++) begin
      smem[i] = init_val(i);
      rmem[i] = init_val(i);
    end
  endtask

  // SRAM model: data only valid in the LATENCY-th cycle of a command.
  assign sram_rdata = (sram_en && ph == LAT - 1) ? smem[sram_addr[11:2]] : 32'hBAD0BAD0;

  initial begin
    ph = 0;
    was_en = 1'b0;
    forever begin
      @(negedge clk);
      if (sram_en && was_en) ph = (ph == LAT - 1) ? 0 : ph + 1;
      else ph = 0;
      was_en = sram_en;
      if (sram_en && sram_we && ph == LAT - 1) smem[sram_addr[11:2]] = sram_wdata;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 0; if_addr = 0; branch_taken = 0;
    mem_rd_en = 0; mem_wr_en = 0; mem_addr = 0; mem_wdata = 0;
    @(negedge clk);
    total++;
    if ({sram_en, sram_we, if_rdy, mem_rdy, freeze, mem_stall} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got %b want 000000", {sram_en, sram_we, if_rdy, mem_rdy, freeze, mem_stall});
    end
    total++;
    if ({sram_addr, sram_wdata} !== 64'b0) begin
      bad++; $display("FAIL reset_sram_bus got %h/%h want 0/0", sram_addr, sram_wdata);
    end
    total++;
    if ({if_rdata, mem_rdata} !== 64'b0) begin
      bad++; $display("FAIL reset_rdata got %h/%h want 0/0", if_rdata, mem_rdata);
    end
    rst = 1'b0;
    cyc(); cyc();
    total++;
    if ({sram_en, if_rdy, mem_rdy} !== 3'b0) begin
      bad++; $display("FAIL idle_after_reset got %b want 000", {sram_en, if_rdy, mem_rdy});
    end
  endtask

  task automatic test_fetch();
    if_req = 1; if_addr = 32'h0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      total++;
      if ({sram_en, if_rdy, freeze} !== {k <= 2, k == 3, k <= 2}) begin
        bad++; $display("FAIL fetch_flags cycle %0d got en/rdy/freeze %b", k, {sram_en, if_rdy, freeze});
      end
      if (k <= 2) begin
        total++;
        if (sram_addr !== 32'h0 || sram_we !== 1'b0) begin
          bad++; $display("FAIL fetch_cmd cycle %0d got addr %h we %b want 0 0", k, sram_addr, sram_we);
        end
      end
      if (k == 3) begin
        total++;
        if (if_rdata !== 32'hE3A00001) begin
          bad++; $display("FAIL fetch_data got %h want e3a00001", if_rdata);
        end
        if_req = 0;
      end
    end
  endtask

  task automatic test_priority();
    int mem_c, if_c;
    mem_c = 0; if_c = 0;
    mem_rd_en = 1; mem_addr = 32'h400; if_req = 1; if_addr = 32'h10;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 1 || k == 3) begin
        total++;
        if (!sram_en || sram_addr !== (k == 1 ? 32'h400 : 32'h10)) begin
          bad++; $display("FAIL prio_cmd cycle %0d got en %b addr %h", k, sram_en, sram_addr);
        end
      end
      if (mem_rdy && mem_c == 0) begin mem_c = k; mem_rd_en = 0; end
      if (if_rdy && if_c == 0) begin if_c = k; if_req = 0; end
    end
    total++;
    if (mem_c != 3 || if_c != 5) begin
      bad++; $display("FAIL prio_order got mem_rdy %0d if_rdy %0d want 3 5", mem_c, if_c);
    end
    total++;
    if (mem_rdata !== init_val(256) || if_rdata !== init_val(4)) begin
      bad++; $display("FAIL prio_data got %h/%h want %h/%h", mem_rdata, if_rdata, init_val(256), init_val(4));
    end
  endtask

  task automatic test_write();
    int mem_c, if_c, we_n;
    mem_c = 0; if_c = 0; we_n = 0;
    mem_wr_en = 1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; if_req = 1; if_addr = 32'h20;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (sram_en && sram_we) we_n++;
      if (k == 1) begin
        total++;
        if (sram_we !== 1'b1 || sram_wdata !== 32'hDEADBEEF || sram_addr !== 32'h100) begin
          bad++; $display("FAIL write_cmd got we %b wdata %h addr %h", sram_we, sram_wdata, sram_addr);
        end
      end
      if (mem_rdy && mem_c == 0) begin mem_c = k; mem_wr_en = 0; end
      if (if_rdy && if_c == 0) begin if_c = k; if_req = 0; end
    end
    total++;
    if (we_n != 2 || mem_c != 3 || if_c != 5) begin
      bad++; $display("FAIL write_timing got we_cycles %0d mem_rdy %0d if_rdy %0d want 2 3 5", we_n, mem_c, if_c);
    end
    total++;
    if (mem_rdata !== init_val(256)) begin
      bad++; $display("FAIL write_keeps_rdata got %h want %h", mem_rdata, init_val(256));
    end
    total++;
    if (smem[64] !== 32'hDEADBEEF || if_rdata !== init_val(8)) begin
      bad++; $display("FAIL write_effect got mem %h if_rdata %h", smem[64], if_rdata);
    end
  endtask

  task automatic test_starve();
    int n;
    n = 0;
    if_req = 1; if_addr = 32'h30; branch_taken = 1; mem_rd_en = 1; mem_addr = 32'h40;
    for (int k = 0; k < 40 && n < SL; k++) begin
      cyc();
      if (mem_rdy) n++;
    end
    total++;
    if (n != SL) begin
      bad++; $display("FAIL starve_mem_grants got %0d want %0d", n, SL);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      total++;
      if (sram_en !== 1'b0) begin
        bad++; $display("FAIL starve_block got sram_en %b want 0", sram_en);
      end
    end
    branch_taken = 0;
    cyc();
    total++;
    if (sram_en !== 1'b1 || sram_addr !== 32'h30 || sram_we !== 1'b0) begin
      bad++; $display("FAIL starve_if_forced got en %b addr %h want 1 00000030", sram_en, sram_addr);
    end
    n = 0;
    for (int k = 0; k < 10 && n == 0; k++) begin
      cyc();
      if (if_rdy) n = 1;
    end
    if_addr = 32'h34; branch_taken = 1;
    n = 0;
    for (int k = 0; k < 25; k++) begin
      cyc();
      if (mem_rdy) n++;
    end
    total++;
    if (n != SL) begin
      bad++; $display("FAIL streak_restart got %0d mem grants want %0d", n, SL);
    end
    total++;
    if (mem_rdata !== init_val(16)) begin
      bad++; $display("FAIL starve_rdata got %h want %h", mem_rdata, init_val(16));
    end
    if_req = 0; mem_rd_en = 0; branch_taken = 0;
    cyc(); cyc();
  endtask

  task automatic test_squash();
    int first, cnt;
    first = 0; cnt = 0;
    if_req = 1; if_addr = 32'h50;
    for (int k = 1; k <= 10; k++) begin
      cyc();
      branch_taken = (k == 1);
      if (k == 1) if_addr = 32'h60;
      if (k == 4) begin
        total++;
        if (sram_en !== 1'b1 || sram_addr !== 32'h60) begin
          bad++; $display("FAIL squash_refetch got en %b addr %h want 1 00000060", sram_en, sram_addr);
        end
      end
      if (if_rdy) begin
        cnt++;
        if (first == 0) first = k;
        if_req = 0;
      end
    end
    total++;
    if (first != 6 || cnt != 1) begin
      bad++; $display("FAIL squash_rdy got first %0d count %0d want 6 1", first, cnt);
    end
    total++;
    if (if_rdata !== init_val(24)) begin
      bad++; $display("FAIL squash_data got %h want %h", if_rdata, init_val(24));
    end
  endtask

  task automatic test_rst_mid();
    int seen, mem_c;
    seen = 0; mem_c = 0;
    mem_rd_en = 1; mem_addr = 32'h80;
    cyc();
    #2 rst = 1'b1;
    #1;
    total++;
    if ({sram_en, sram_we, mem_rdy, if_rdy} !== 4'b0 || sram_addr !== 0 || mem_rdata !== 0 || if_rdata !== 0) begin
      bad++; $display("FAIL rst_async got flags %b addr %h rdata %h/%h", {sram_en, sram_we, mem_rdy, if_rdy}, sram_addr, mem_rdata, if_rdata);
    end
    repeat (2) begin
      @(negedge clk);
      if (mem_rdy || sram_en) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_hold got %0d active cycles want 0", seen);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (mem_rdy && mem_c == 0) begin mem_c = k; mem_rd_en = 0; end
    end
    total++;
    if (mem_c != 3 || mem_rdata !== init_val(32)) begin
      bad++; $display("FAIL rst_restart got rdy %0d rdata %h want 3 %h", mem_c, mem_rdata, init_val(32));
    end
  endtask

  task automatic test_random();
    logic        if_pend, mem_pend, mem_is_wr;
    int          if_wait, mem_wait;
    logic [31:0] a_prev, last_load;
    if_pend = 0; mem_pend = 0; mem_is_wr = 0; if_wait = 0; mem_wait = 0;
    last_load = init_val(32);
    init_mems();
    a_prev = if_addr;
    for (int c = 0; c < 3200; c++) begin
      cyc();
      if (if_pend) if_wait++;
      if (mem_pend) mem_wait++;
      if (if_rdy) begin
        total++;
        if (!if_pend || if_rdata !== rmem[a_prev[11:2]] || if_wait > 20) begin
          bad++; $display("FAIL rand_fetch cycle %0d addr %h got %h want %h wait %0d", c, a_prev, if_rdata, rmem[a_prev[11:2]], if_wait);
        end
        if_pend = 0; if_req = 0;
      end
      if (mem_rdy) begin
        if (mem_is_wr) rmem[mem_addr[11:2]] = mem_wdata;
        else last_load = rmem[mem_addr[11:2]];
        total++;
        if (!mem_pend || mem_rdata !== last_load || mem_wait > 20) begin
          bad++; $display("FAIL rand_mem cycle %0d addr %h wr %b got %h want %h wait %0d", c, mem_addr, mem_is_wr, mem_rdata, last_load, mem_wait);
        end
        mem_pend = 0; mem_rd_en = 0; mem_wr_en = 0;
      end
      if ((if_pend && if_wait > 40) || (mem_pend && mem_wait > 40)) begin
        total++; bad++;
        $display("FAIL rand_timeout cycle %0d if_wait %0d mem_wait %0d", c, if_wait, mem_wait);
        break;
      end
      if (c >= 3000 && !if_pend && !mem_pend) break;
      a_prev = if_addr;
      branch_taken = 0;
      if (if_pend && $urandom_range(0, 15) == 0) begin
        branch_taken = 1; if_addr = 32'($urandom_range(0, 63)) << 2; if_wait = 0;
      end else if (!if_pend && c < 3000 && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = 32'($urandom_range(0, 63)) << 2; if_pend = 1; if_wait = 0;
      end
      if (!mem_pend && c < 3000 && $urandom_range(0, 2) == 0) begin
        mem_is_wr = 1'($urandom_range(0, 1));
        mem_rd_en = ~mem_is_wr; mem_wr_en = mem_is_wr;
        mem_addr = 32'($urandom_range(0, 63)) << 2;
        mem_wdata = $urandom;
        mem_pend = 1; mem_wait = 0;
      end
    end
    branch_taken = 0; if_req = 0; mem_rd_en = 0; mem_wr_en = 0;
  endtask

  initial begin
    init_mems();
    test_reset();
    test_fetch();
    test_priority();
    test_write();
    test_starve();
    test_squash();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
